debounce_edge_amisha: RTL and testbench

Debounces and edge-detects a single-bit level that has already been registered into the `clk_amisha` domain by the team's D flip-flop stage. It sits directly downstream of that flip-flop: the flip-flop's `q` output drives `din_amisha`. The block outputs a clean level, one-cycle rise and fall pulses, and a wrapping count of accepted rising edges for control logic and status registers.

---
 rtl/debounce_edge_amisha_pkg.sv | 27 ++
 rtl/debounce_edge_amisha.sv | 123 ++++++++++++
 tb/tb_debounce_edge_amisha.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_edge_amisha_pkg.sv
// Shared definitions for the debounce / edge-detect block.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   IDLE_LOW / WAIT_HIGH / IDLE_HIGH / WAIT_LOW : 2-bit FSM state encoding
//   cnt_width()                                 : minimum stability-counter width
package debounce_pkg_amisha;

  // Bit 0 set marks the two WAIT states; bit 1 is the level being held or left.
  localparam logic [1:0] IDLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH = 2'b10;
  localparam logic [1:0] WAIT_LOW  = 2'b11;

  // Smallest width w with 2^w > stable_cycles - 1, so the counter can reach
  // its terminal value stable_cycles - 1 without overflowing.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = 1;
    while ((1 << w) <= (stable_cycles - 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_edge_amisha.sv
// Debounces a registered single-bit level; emits clean level, rise/fall pulses, rise count.
// Latency: output changes on the STABLE_CYCLES-th consecutive edge sampling the new level.
// Backpressure: none; the block samples every cycle and its outputs are never stalled.
//
// Ports:
//   clk_amisha      in   clock, all state updates on rising edge
//   rst_n_amisha    in   asynchronous active-low reset
//   din_amisha      in   raw level, already registered into clk_amisha
//   db_out_amisha   out  debounced level
//   rise_amisha     out  one-cycle pulse on an accepted 0->1 transition
//   fall_amisha     out  one-cycle pulse on an accepted 1->0 transition
//   busy_amisha     out  high while a candidate transition is being timed
//   evt_cnt_amisha  out  wrapping count of accepted rising edges
module debounce_edge_amisha
  import debounce_pkg_amisha::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter int EVT_W         = 8,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             din_amisha,
  output logic             db_out_amisha,
  output logic             rise_amisha,
  output logic             fall_amisha,
  output logic             busy_amisha,
  output logic [EVT_W-1:0] evt_cnt_amisha
);

  localparam logic [1:0]       RESET_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_ONE     = EVT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept_rise;
  logic             accept_fall;

  // State and stability counter.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state. The first edge sampling the new level counts as one, so the
  // STABLE_CYCLES-th such edge is the one that sees cnt == STABLE_CYCLES - 1.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (din_amisha) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!din_amisha) begin
          state_nxt = IDLE_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE_HIGH;
          accept_rise = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!din_amisha) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (din_amisha) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE_LOW;
          accept_fall = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  // Registered outputs, all updated on the same edge as the state register so
  // db_out and its pulse line up with the accepting transition.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      db_out_amisha  <= RESET_LEVEL;
      rise_amisha    <= 1'b0;
      fall_amisha    <= 1'b0;
      busy_amisha    <= 1'b0;
      evt_cnt_amisha <= '0;
    end else begin
      rise_amisha <= accept_rise;
      fall_amisha <= accept_fall;
      busy_amisha <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
      if (accept_rise) begin
        db_out_amisha  <= 1'b1;
        evt_cnt_amisha <= evt_cnt_amisha + EVT_ONE;
      end else if (accept_fall) begin
        db_out_amisha <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge_amisha.sv
// Self-checking bench for debounce_edge_amisha: directed scenarios plus random runs.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_edge_amisha;
  import debounce_pkg_amisha::*;

  localparam int S_A    = 4;
  localparam int EVTW_A = 2;
  localparam int S_B    = 3;
  localparam int EVTW_B = 8;

  logic clk_amisha;
  logic rst_n_amisha;
  logic din_amisha;

  logic              db_a, rise_a, fall_a, busy_a;
  logic [EVTW_A-1:0] evt_a;
  logic              db_b, rise_b, fall_b, busy_b;
  logic [EVTW_B-1:0] evt_b;

  int checks = 0;
  int errors = 0;

  debounce_edge_amisha #(
    .STABLE_CYCLES(S_A),
    .CNT_W        (cnt_width(S_A)),
    .EVT_W        (EVTW_A),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk_amisha    (clk_amisha),
    .rst_n_amisha  (rst_n_amisha),
    .din_amisha    (din_amisha),
    .db_out_amisha (db_a),
    .rise_amisha   (rise_a),
    .fall_amisha   (fall_a),
    .busy_amisha   (busy_a),
    .evt_cnt_amisha(evt_a)
  );

  debounce_edge_amisha #(
    .STABLE_CYCLES(S_B),
    .CNT_W        (5),
    .EVT_W        (EVTW_B),
    .RESET_LEVEL  (1'b1)
  ) dut_b (
    .clk_amisha    (clk_amisha),
    .rst_n_amisha  (rst_n_amisha),
    .din_amisha    (din_amisha),
    .db_out_amisha (db_b),
    .rise_amisha   (rise_b),
    .fall_amisha   (fall_b),
    .busy_amisha   (busy_b),
    .evt_cnt_amisha(evt_b)
  );

  initial clk_amisha = 1'b0;
  always #5 clk_amisha = ~clk_amisha;

  // Behavioural model: the debounced level flips once S consecutive samples
  // disagree with it; "run" is the length of the current disagreeing streak.
  typedef struct packed {
    logic        db;
    logic        rise;
    logic        fall;
    logic [31:0] run;
    logic [31:0] evt;
  } m_t;

  function automatic m_t m_reset(input logic lvl);
    m_t r;
    r.db = lvl; r.rise = 1'b0; r.fall = 1'b0; r.run = 0; r.evt = 0;
    return r;
  endfunction

  function automatic m_t m_step(input m_t c, input logic d, input int s, input int evtw);
    m_t n;
    n = c;
    n.rise = 1'b0;
    n.fall = 1'b0;
    n.run  = (d != c.db) ? c.run + 1 : 0;
    if (n.run == s) begin
      n.db  = d;
      n.run = 0;
      if (d) begin
        n.rise = 1'b1;
        n.evt  = (c.evt + 1) % (1 << evtw);
      end else begin
        n.fall = 1'b1;
      end
    end
    return n;
  endfunction

  m_t ma, mb;

  always @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      ma <= m_reset(1'b0);
      mb <= m_reset(1'b1);
    end else begin
      ma <= m_step(ma, din_amisha, S_A, EVTW_A);
      mb <= m_step(mb, din_amisha, S_B, EVTW_B);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_amisha);
      chk("a_db",   int'(db_a),   int'(ma.db));
      chk("a_rise", int'(rise_a), int'(ma.rise));
      chk("a_fall", int'(fall_a), int'(ma.fall));
      chk("a_busy", int'(busy_a), int'(ma.run != 0));
      chk("a_evt",  int'(evt_a),  int'(ma.evt));
      chk("b_db",   int'(db_b),   int'(mb.db));
      chk("b_rise", int'(rise_b), int'(mb.rise));
      chk("b_fall", int'(fall_b), int'(mb.fall));
      chk("b_busy", int'(busy_b), int'(mb.run != 0));
      chk("b_evt",  int'(evt_b),  int'(mb.evt));
    end
  end

  // Advance to 3 time units after the next rising edge.
  task automatic tick();
    @(posedge clk_amisha);
    #3;
  endtask

  logic lvl;
  int   len;
  int   wrap_exp [4] = '{2, 3, 0, 1};

  initial begin
    rst_n_amisha = 1'b0;
    din_amisha   = 1'b1;

    // Reset held with din high: outputs stay at reset values.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_db",   int'(db_a),   0);
      chk("rst_rise", int'(rise_a), 0);
      chk("rst_evt",  int'(evt_a),  0);
      chk("rst_b_db", int'(db_b),   1);
    end
    rst_n_amisha = 1'b1;

    // Clean rise: accepted on the 4th sampling edge.
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        chk("rise_busy", int'(busy_a), 1);
        chk("rise_wait_db", int'(db_a), 0);
        chk("rise_early", int'(rise_a), 0);
      end else begin
        chk("rise_pulse", int'(rise_a), 1);
        chk("rise_db",    int'(db_a),   1);
        chk("rise_evt",   int'(evt_a),  1);
        chk("rise_idle",  int'(busy_a), 0);
      end
    end
    tick();
    chk("rise_one_cycle", int'(rise_a), 0);
    chk("rise_db_hold",   int'(db_a),   1);

    // Fall.
    din_amisha = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        chk("fall_early", int'(fall_a), 0);
        chk("fall_wait_db", int'(db_a), 1);
      end else begin
        chk("fall_pulse", int'(fall_a), 1);
        chk("fall_db",    int'(db_a),   0);
        chk("fall_evt",   int'(evt_a),  1);
      end
    end

    // Glitch: three edges high then low.
    din_amisha = 1'b1;
    repeat (3) tick();
    chk("glitch_busy", int'(busy_a), 1);
    din_amisha = 1'b0;
    tick();
    chk("glitch_busy_drop", int'(busy_a), 0);
    chk("glitch_db",        int'(db_a),   0);
    chk("glitch_rise",      int'(rise_a), 0);
    chk("glitch_evt",       int'(evt_a),  1);

    // Wrap of the 2-bit event counter over rises 2..5.
    for (int r = 0; r < 4; r++) begin
      din_amisha = 1'b1;
      repeat (4) tick();
      chk("wrap_rise", int'(rise_a), 1);
      chk("wrap_evt",  int'(evt_a),  wrap_exp[r]);
      din_amisha = 1'b0;
      repeat (4) tick();
      chk("wrap_fall", int'(fall_a), 1);
    end

    // Reset mid-WAIT with cnt = 2.
    din_amisha = 1'b1;
    repeat (2) tick();
    chk("midwait_cnt",  int'(dut.cnt), 2);
    chk("midwait_busy", int'(busy_a),  1);
    #1 rst_n_amisha = 1'b0;
    #1;
    chk("midrst_state", int'(dut.state), int'(IDLE_LOW));
    chk("midrst_cnt",   int'(dut.cnt),   0);
    chk("midrst_busy",  int'(busy_a),    0);
    chk("midrst_evt",   int'(evt_a),     0);
    repeat (2) tick();
    chk("midrst_rise", int'(rise_a), 0);
    rst_n_amisha = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("fresh_rise", int'(rise_a), (k == 4) ? 1 : 0);
      chk("fresh_db",   int'(db_a),   (k == 4) ? 1 : 0);
    end
    chk("fresh_evt", int'(evt_a), 1);

    // Random runs of varying length, with occasional mid-cycle resets.
    lvl = din_amisha;
    for (int i = 0; i < 3000; ) begin
      lvl = ~lvl;
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        tick();
        din_amisha = lvl;
        if ($urandom_range(0, 199) == 0) begin
          #1 rst_n_amisha = 1'b0;
          tick();
          rst_n_amisha = 1'b1;
        end
        i++;
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
